// File: rtl/noc_stream_pkg.sv
// Shared types and helpers for the NoC stream fan-out blocks.
package noc_stream_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // Select width; a single-port block still carries a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry registered output stage: holds a beat until its consumer takes it,
// and can be reloaded in the same cycle it drains.
module stream_slot
    import noc_stream_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_can_accept
);

    slot_state_e  r_state;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (i_wr) begin
                        r_state <= FULL;
                        r_data  <= i_data;
                    end
                end
                FULL: begin
                    if (i_wr) begin
                        r_data <= i_data;
                    end else if (i_ready) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign o_data       = r_data;
    assign o_valid      = (r_state == FULL);
    assign o_can_accept = (r_state == EMPTY) || i_ready;

`ifndef SYNTHESIS
    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (o_valid && !i_ready) |=> (o_valid && $stable(o_data)));

    a_wr_when_free: assert property (@(posedge clk) disable iff (!rst_n)
        i_wr |-> o_can_accept);
`endif

endmodule

// File: rtl/stream_demux.sv
// 1:N valid/ready stream steering with a per-port one-entry slot, so a stalled
// consumer only blocks beats addressed to it. Out-of-range selects are dropped.
module stream_demux
    import noc_stream_pkg::*;
#(
    parameter  int unsigned N     = 2,
    parameter  int unsigned W     = 32,
    parameter  int unsigned CNT_W = CNT_W_DEF,
    localparam int unsigned L     = sel_width(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [L-1:0]        in_s,
    input  logic [W-1:0]        in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [N-1:0][W-1:0] out_data,
    output logic [N-1:0]        out_valid,
    input  logic [N-1:0]        out_ready,
    output logic [CNT_W-1:0]    drop_count,
    output logic                drop_pulse
);

    logic [L-1:0]     w_idx;
    logic             w_in_range;
    logic             w_drop;
    logic [N-1:0]     w_can_accept;
    logic [N-1:0]     w_wr;
    logic [CNT_W-1:0] r_drop_count;
    logic             r_drop_pulse;

    // The range check only exists when N leaves unused select codes.
    generate
        if (N == 1) begin : g_single
            logic w_unused_s;
            assign w_unused_s = ^in_s;
            assign w_idx      = '0;
            assign w_in_range = 1'b1;
        end else if ((N & (N - 1)) == 0) begin : g_pow2
            assign w_idx      = in_s;
            assign w_in_range = 1'b1;
        end else begin : g_bounded
            assign w_idx      = in_s;
            assign w_in_range = (32'(in_s) < N);
        end
    endgenerate

    assign in_ready = w_in_range ? w_can_accept[w_idx] : 1'b1;
    assign w_drop   = in_valid && !w_in_range;

    for (genvar k = 0; k < N; k = k + 1) begin : g_slot
        assign w_wr[k] = in_valid && in_ready && w_in_range && (w_idx == L'(k));

        stream_slot #(
            .W (W)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_wr         (w_wr[k]),
            .i_data       (in_data),
            .i_ready      (out_ready[k]),
            .o_data       (out_data[k]),
            .o_valid      (out_valid[k]),
            .o_can_accept (w_can_accept[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign drop_count = r_drop_count;
    assign drop_pulse = r_drop_pulse;

`ifndef SYNTHESIS
    a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready) |=> ($stable(in_s) && $stable(in_data)));

    a_one_write: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(w_wr));
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-port instance and a 3-port instance with a 2-bit
// drop counter, each compared against a per-port occupancy model every cycle.
module tb_stream_demux;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       a_s;
    logic [31:0]      a_data;
    logic             a_valid, a_ready;
    logic [3:0][31:0] a_odata;
    logic [3:0]       a_ovalid, a_ordy;
    logic [15:0]      a_cnt;
    logic             a_pulse;

    logic [1:0]       b_s;
    logic [31:0]      b_data;
    logic             b_valid, b_ready;
    logic [2:0][31:0] b_odata;
    logic [2:0]       b_ovalid, b_ordy;
    logic [1:0]       b_cnt;
    logic             b_pulse;

    stream_demux #(.N(4), .W(32), .CNT_W(16)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_s       (a_s),
        .in_data    (a_data),
        .in_valid   (a_valid),
        .in_ready   (a_ready),
        .out_data   (a_odata),
        .out_valid  (a_ovalid),
        .out_ready  (a_ordy),
        .drop_count (a_cnt),
        .drop_pulse (a_pulse)
    );

    stream_demux #(.N(3), .W(32), .CNT_W(2)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_s       (b_s),
        .in_data    (b_data),
        .in_valid   (b_valid),
        .in_ready   (b_ready),
        .out_data   (b_odata),
        .out_valid  (b_ovalid),
        .out_ready  (b_ordy),
        .drop_count (b_cnt),
        .drop_pulse (b_pulse)
    );

    int unsigned n_checks;
    int unsigned n_errors;

    // Model: each port either holds one beat or nothing; index 0 = DUT A, 1 = DUT B.
    int          m_nports [2] = '{4, 3};
    int          m_cmax   [2] = '{65535, 3};
    bit          m_full   [2][4];
    logic [31:0] m_word   [2][4];
    int          m_cnt    [2];
    bit          m_pulse  [2];
    bit          m_rdy    [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                m_full[d][k] = 1'b0;
                m_word[d][k] = '0;
            end
            m_cnt[d]   = 0;
            m_pulse[d] = 1'b0;
        end
    endtask

    function automatic bit m_ready(input int d, input int s, input logic [3:0] ordy);
        if (s >= m_nports[d]) return 1'b1;
        return !m_full[d][s] || ordy[s];
    endfunction

    task automatic m_edge(input int d, input bit valid, input int s,
                          input logic [31:0] data, input logic [3:0] ordy);
        bit acc;
        acc = valid && m_ready(d, s, ordy);
        for (int k = 0; k < m_nports[d]; k++)
            if (m_full[d][k] && ordy[k]) m_full[d][k] = 1'b0;
        m_pulse[d] = 1'b0;
        if (acc) begin
            if (s < m_nports[d]) begin
                m_full[d][s] = 1'b1;
                m_word[d][s] = data;
            end else begin
                m_pulse[d] = 1'b1;
                if (m_cnt[d] < m_cmax[d]) m_cnt[d]++;
            end
        end
    endtask

    task automatic chk_outputs();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("a_ovalid%0d", k), 64'(a_ovalid[k]), 64'(m_full[0][k]));
            if (m_full[0][k]) chk($sformatf("a_odata%0d", k), 64'(a_odata[k]), 64'(m_word[0][k]));
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b_ovalid%0d", k), 64'(b_ovalid[k]), 64'(m_full[1][k]));
            if (m_full[1][k]) chk($sformatf("b_odata%0d", k), 64'(b_odata[k]), 64'(m_word[1][k]));
        end
        chk("a_drop_count", 64'(a_cnt), 64'(m_cnt[0]));
        chk("a_drop_pulse", 64'(a_pulse), 64'(m_pulse[0]));
        chk("b_drop_count", 64'(b_cnt), 64'(m_cnt[1]));
        chk("b_drop_pulse", 64'(b_pulse), 64'(m_pulse[1]));
    endtask

    // Inputs are set at the falling edge; check in_ready, clock, then check outputs.
    task automatic cyc();
        #1;
        m_rdy[0] = m_ready(0, int'(a_s), a_ordy);
        m_rdy[1] = m_ready(1, int'(b_s), {1'b0, b_ordy});
        chk("a_in_ready", 64'(a_ready), 64'(m_rdy[0]));
        chk("b_in_ready", 64'(b_ready), 64'(m_rdy[1]));
        @(posedge clk);
        if (rst_n) begin
            m_edge(0, a_valid, int'(a_s), a_data, a_ordy);
            m_edge(1, b_valid, int'(b_s), b_data, {1'b0, b_ordy});
        end
        @(negedge clk);
        chk_outputs();
    endtask

    task automatic drain();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_ordy  = '1;
        b_ordy  = '1;
        cyc();
    endtask

    int exp_cnt;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        a_s = '0; a_data = '0; a_valid = 1'b0; a_ordy = '0;
        b_s = '0; b_data = '0; b_valid = 1'b0; b_ordy = '0;
        m_reset();

        // Reset held with random traffic
        repeat (3) begin
            a_s = 2'($urandom); a_data = $urandom; a_valid = 1'($urandom); a_ordy = 4'($urandom);
            b_s = 2'($urandom); b_data = $urandom; b_valid = 1'($urandom); b_ordy = 3'($urandom);
            cyc();
        end
        chk("t1_rst_ovalid", 64'(a_ovalid), 64'(4'h0));
        chk("t1_rst_cnt", 64'(a_cnt), 64'(16'h0));
        rst_n   = 1'b1;
        a_valid = 1'b0; a_ordy = '0;
        b_valid = 1'b0; b_ordy = '0;
        a_s = 2'd2; a_data = 32'hA5; a_valid = 1'b1;
        cyc();
        a_valid = 1'b0;
        chk("t1_ovalid", 64'(a_ovalid), 64'(4'b0100));
        chk("t1_odata2", 64'(a_odata[2]), 64'(32'hA5));

        // Back-to-back streaming to port 1
        drain();
        a_ordy = '1; a_s = 2'd1; a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_data = 32'h100 + 32'(i);
            cyc();
            chk($sformatf("t2_ready%0d", i), 64'(a_ready), 64'(1'b1));
            chk($sformatf("t2_beat%0d", i), 64'(a_odata[1]), 64'(32'h100 + 32'(i)));
        end
        a_valid = 1'b0;

        // Stalled port 0 must not block port 3
        drain();
        a_ordy = 4'b1110; a_s = 2'd0; a_data = 32'h11; a_valid = 1'b1;
        cyc();
        a_data = 32'h99;
        cyc();
        chk("t3_stall_ready", 64'(a_ready), 64'(1'b0));
        chk("t3_hold", 64'(a_odata[0]), 64'(32'h11));
        a_valid = 1'b0;
        cyc();
        a_s = 2'd3; a_data = 32'h33; a_valid = 1'b1;
        cyc();
        a_valid = 1'b0;
        chk("t3_v3", 64'(a_ovalid[3]), 64'(1'b1));
        chk("t3_port3", 64'(a_odata[3]), 64'(32'h33));
        chk("t3_port0", 64'(a_odata[0]), 64'(32'h11));

        // Drain and refill slot 1 in the same cycle
        drain();
        a_ordy = '0; a_s = 2'd1; a_data = 32'h22; a_valid = 1'b1;
        cyc();
        a_ordy = 4'b0010; a_data = 32'h33;
        cyc();
        a_valid = 1'b0;
        chk("t4_v1", 64'(a_ovalid[1]), 64'(1'b1));
        chk("t4_d1", 64'(a_odata[1]), 64'(32'h33));

        // Drops on the 3-port instance saturate the 2-bit counter
        drain();
        b_s = 2'd3; b_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_data = $urandom;
            cyc();
            exp_cnt = (i < 2) ? i + 1 : 3;
            chk($sformatf("t5_pulse%0d", i), 64'(b_pulse), 64'(1'b1));
            chk($sformatf("t5_cnt%0d", i), 64'(b_cnt), 64'(exp_cnt));
            chk($sformatf("t5_novalid%0d", i), 64'(b_ovalid), 64'(3'b000));
        end
        b_valid = 1'b0;
        cyc();
        chk("t5_pulse_end", 64'(b_pulse), 64'(1'b0));
        chk("t5_cnt_end", 64'(b_cnt), 64'(2'd3));

        // Asynchronous reset between edges with slots occupied
        drain();
        a_ordy = '0; a_valid = 1'b1;
        a_s = 2'd0; a_data = 32'h40;
        cyc();
        a_s = 2'd2; a_data = 32'h42;
        cyc();
        a_valid = 1'b0;
        chk("t6_pre", 64'(a_ovalid), 64'(4'b0101));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_clear", 64'(a_ovalid), 64'(4'b0000));
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        a_s = 2'd0; a_data = 32'h55; a_valid = 1'b1;
        cyc();
        a_valid = 1'b0;
        chk("t6_ovalid", 64'(a_ovalid), 64'(4'b0001));
        chk("t6_odata0", 64'(a_odata[0]), 64'(32'h55));

        // Random traffic; a stalled beat is held until accepted
        drain();
        for (int c = 0; c < 400; c++) begin
            if (!(a_valid && !m_rdy[0])) begin
                a_valid = ($urandom % 4) != 0;
                a_s     = 2'($urandom);
                a_data  = $urandom;
            end
            if (!(b_valid && !m_rdy[1])) begin
                b_valid = ($urandom % 4) != 0;
                b_s     = 2'($urandom);
                b_data  = $urandom;
            end
            a_ordy = 4'($urandom);
            b_ordy = 3'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
